// File: rtl/button_reader_if.sv
// rtl/button_reader_if.sv - event handshake bundle between button_reader and its consumer
//
// Parameter N          : number of input channels, sizes evt_chan
// evt_valid    (m->s)  : event register holds an unconsumed event
// evt_ready    (s->m)  : consumer accepts on evt_valid && evt_ready
// evt_chan     (m->s)  : channel index of the event
// evt_press    (m->s)  : 1 = press, 0 = release
// evt_overflow (m->s)  : sticky, an unreported change was overwritten
// evt_long     (m->s)  : long-press event, only with BUTTON_READER_LONGPRESS_EN
interface button_reader_if #(
  parameter int N = 5
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_chan;
  logic          evt_press;
  logic          evt_overflow;
`ifdef BUTTON_READER_LONGPRESS_EN
  logic          evt_long;

  modport master (
    output evt_valid, evt_chan, evt_press, evt_overflow, evt_long,
    input  evt_ready
  );
  modport slave (
    input  evt_valid, evt_chan, evt_press, evt_overflow, evt_long,
    output evt_ready
  );
`else
  modport master (
    output evt_valid, evt_chan, evt_press, evt_overflow,
    input  evt_ready
  );
  modport slave (
    input  evt_valid, evt_chan, evt_press, evt_overflow,
    output evt_ready
  );
`endif
endinterface

// File: rtl/button_reader.sv
// rtl/button_reader.sv - synchronize, debounce and report button level changes as events
//
// Optional feature macro: BUTTON_READER_LONGPRESS_EN (adds long-press events, evt.evt_long)
// clk   in  : internal oscillator clock
// rst   in  : synchronous active-high reset
// pins  in  : raw pin levels, 1 = pressed, asynchronous to clk
// level out : debounced stable level per channel
// evt       : button_reader_if.master event handshake (valid/ready, chan, press, overflow)
module button_reader #(
  parameter int N            = 5,
  parameter int TICK_DIV     = 11,
  parameter int DEBOUNCE_CNT = 16,
  parameter int LONG_TICKS   = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   pins,
  output logic [N-1:0]   level,
  button_reader_if.master evt
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || N > 8) begin : g_bad_n
    $error("button_reader: N must be in 1..8");
  end
  if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 255) begin : g_bad_deb
    $error("button_reader: DEBOUNCE_CNT must be in 2..255");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("button_reader: LONG_TICKS must be at least 1");
  end

  logic [N-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TICK_DIV-1:0] div_q, div_d;
  logic                tick;
  logic [7:0]          cnt_q [N];
  logic [7:0]          cnt_d [N];
  logic [N-1:0]        level_q, level_d, flip;
  logic [N-1:0]        pend_q, pend_d, pend_lvl_q, pend_lvl_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CW-1:0]       evt_chan_q, evt_chan_d;
  logic                evt_press_q, evt_press_d;
  logic                ovf_q, ovf_d;
  logic                free;
  logic [N-1:0]        cand, sel_oh, take_pend;
  logic [CW-1:0]       sel_idx;

`ifdef BUTTON_READER_LONGPRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];
  logic [N-1:0]  long_q, long_d, take_long;
  logic          evt_long_q, evt_long_d;
`endif

  assign tick = &div_q;

  always_comb begin
    sync1_d     = pins;
    sync2_d     = sync1_q;
    div_d       = div_q + 1'b1;
    level_d     = level_q;
    flip        = '0;
    pend_d      = pend_q;
    pend_lvl_d  = pend_lvl_q;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    evt_press_d = evt_press_q;
    ovf_d       = ovf_q;
    sel_oh      = '0;
    sel_idx     = '0;
    take_pend   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
`ifdef BUTTON_READER_LONGPRESS_EN
    long_d     = long_q;
    take_long  = '0;
    evt_long_d = evt_long_q;
    for (int i = 0; i < N; i++) begin
      hold_d[i] = hold_q[i];
    end
    cand = pend_q | long_q;
`else
    cand = pend_q;
`endif

    // Debounce: a level flip needs DEBOUNCE_CNT consecutive differing ticks.
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == 8'(DEBOUNCE_CNT - 1)) begin
            level_d[i] = ~level_q[i];
            flip[i]    = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end

    // Lowest-indexed candidate wins: scan downward so the last hit is the lowest.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
        sel_idx = CW'(i);
      end
    end

    free = !evt_valid_q || evt.evt_ready;
    if (free) begin
      if (|sel_oh) begin
        evt_valid_d = 1'b1;
        evt_chan_d  = sel_idx;
        take_pend   = sel_oh & pend_q;
`ifdef BUTTON_READER_LONGPRESS_EN
        // A level change on the channel outranks its long-press report.
        take_long   = sel_oh & ~pend_q;
        evt_press_d = (|take_pend) ? (|(pend_lvl_q & take_pend)) : 1'b1;
        evt_long_d  = |take_long;
`else
        evt_press_d = |(pend_lvl_q & take_pend);
`endif
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    pend_d = pend_q & ~take_pend;

`ifdef BUTTON_READER_LONGPRESS_EN
    long_d = long_q & ~take_long;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (level_q[i] && hold_q[i] != HW'(LONG_TICKS)) begin
          hold_d[i] = hold_q[i] + 1'b1;
          if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
            long_d[i] = 1'b1;
          end
        end
      end
    end
`endif

    // A pending change that is being loaded this edge is not lost, so no overflow.
    for (int i = 0; i < N; i++) begin
      if (flip[i]) begin
        if (pend_q[i] && !take_pend[i]) begin
          ovf_d = 1'b1;
        end
        pend_d[i]     = 1'b1;
        pend_lvl_d[i] = level_d[i];
`ifdef BUTTON_READER_LONGPRESS_EN
        if (!level_d[i]) begin
          hold_d[i] = '0;
          long_d[i] = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      div_q       <= '0;
      level_q     <= '0;
      pend_q      <= '0;
      pend_lvl_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      evt_press_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef BUTTON_READER_LONGPRESS_EN
      long_q     <= '0;
      evt_long_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        hold_q[i] <= '0;
      end
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_q       <= div_d;
      level_q     <= level_d;
      pend_q      <= pend_d;
      pend_lvl_q  <= pend_lvl_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      evt_press_q <= evt_press_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef BUTTON_READER_LONGPRESS_EN
      long_q     <= long_d;
      evt_long_q <= evt_long_d;
      for (int i = 0; i < N; i++) begin
        hold_q[i] <= hold_d[i];
      end
`endif
    end
  end

  assign level            = level_q;
  assign evt.evt_valid    = evt_valid_q;
  assign evt.evt_chan     = evt_chan_q;
  assign evt.evt_press    = evt_press_q;
  assign evt.evt_overflow = ovf_q;
`ifdef BUTTON_READER_LONGPRESS_EN
  assign evt.evt_long     = evt_long_q;
`endif
endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - randomized and directed self-checking bench for button_reader
module tb_button_reader;
  localparam int N  = 5;
  localparam int TD = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pins;
  logic [N-1:0] level;

  button_reader_if #(.N(N)) bus ();

  button_reader #(
    .N(N), .TICK_DIV(TD), .DEBOUNCE_CNT(DC), .LONG_TICKS(1000)
  ) dut (
    .clk(clk), .rst(rst), .pins(pins), .level(level), .evt(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [N-1:0] m_hist[$];
  int         m_e;
  int         m_cnt [N];
  bit [N-1:0] m_lvl, m_pend, m_plvl;
  bit         m_v, m_pr, m_ovf;
  bit [2:0]   m_ch;

  logic [3:0] hs_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] s, nl;
    bit         tk, fr;
    int         took;
    if (rst) begin
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
      m_e = 0; m_lvl = '0; m_pend = '0; m_plvl = '0;
      m_v = 0; m_pr = 0; m_ovf = 0; m_ch = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(pins);
    tk = (m_e % (1 << TD)) == ((1 << TD) - 1);
    m_e++;
    nl = m_lvl;
    if (tk) begin
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DC) begin
            nl[i] = ~m_lvl[i];
            m_cnt[i] = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    fr = !m_v || bus.evt_ready;
    if (fr) begin
      took = -1;
      for (int i = 0; i < N; i++) if (m_pend[i] && took < 0) took = i;
      if (took >= 0) begin
        m_v = 1; m_ch = 3'(took); m_pr = m_plvl[took]; m_pend[took] = 0;
      end else begin
        m_v = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (nl[i] != m_lvl[i]) begin
        if (m_pend[i]) m_ovf = 1;
        m_pend[i] = 1;
        m_plvl[i] = nl[i];
      end
    end
    m_lvl = nl;
  endtask

  task automatic step(input logic [N-1:0] p, input logic r, input logic rs);
    pins = p;
    bus.evt_ready = r;
    rst = rs;
    if (!rs && bus.evt_valid && r) hs_log.push_back({bus.evt_chan, bus.evt_press});
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("level", level, m_lvl);
    check("evt", {bus.evt_valid, bus.evt_chan, bus.evt_press}, {m_v, m_ch, m_pr});
    check("ovf", bus.evt_overflow, m_ovf);
  endtask

  task automatic run(input logic [N-1:0] p, input logic r, input int n);
    for (int k = 0; k < n; k++) step(p, r, 1'b0);
  endtask

  initial begin
    int         lat;
    logic [N-1:0] cur;
    logic       rdy, rs;
    rst = 1'b1;
    pins = '0;
    bus.evt_ready = 1'b0;
    @(negedge clk);

    // Reset with all pins asserted
    for (int k = 0; k < 10; k++) step(5'b11111, 1'b0, 1'b1);
    check("rst_level", level, 0);
    check("rst_valid", bus.evt_valid, 0);
    check("rst_ovf", bus.evt_overflow, 0);
    run(5'b00000, 1'b1, 5);

    // Clean press on channel 2
    hs_log.delete();
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step(5'b00100, 1'b1, 1'b0);
      if (lat == 0 && level[2]) lat = k;
    end
    check("press_lat", (lat > 0 && lat <= 22), 1);
    check("press_n", hs_log.size(), 1);
    if (hs_log.size() > 0) check("press_evt", hs_log[0], {3'd2, 1'b1});
    run(5'b00000, 1'b1, 30);
    check("release_n", hs_log.size(), 2);
    if (hs_log.size() > 1) check("release_evt", hs_log[1], {3'd2, 1'b0});

    // Bouncing channel 0 never settles long enough
    hs_log.delete();
    for (int t = 0; t < 60; t++) step(((t / 6) % 2 == 0) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
    run(5'b00000, 1'b1, 30);
    check("bounce_n", hs_log.size(), 0);
    check("bounce_level", level, 0);

    // Simultaneous press on 1 and 4, consumer stalled
    hs_log.delete();
    run(5'b10010, 1'b0, 40);
    check("simul_hold", {bus.evt_valid, bus.evt_chan, bus.evt_press}, {1'b1, 3'd1, 1'b1});
    run(5'b10010, 1'b1, 4);
    check("simul_n", hs_log.size(), 2);
    if (hs_log.size() > 1) begin
      check("simul_first", hs_log[0], {3'd1, 1'b1});
      check("simul_second", hs_log[1], {3'd4, 1'b1});
    end
    check("simul_idle", bus.evt_valid, 0);
    run(5'b00000, 1'b1, 30);

    // Overflow: repeated changes on channel 3 while stalled
    hs_log.delete();
    run(5'b01000, 1'b0, 30);
    run(5'b00000, 1'b0, 30);
    run(5'b01000, 1'b0, 30);
    run(5'b00000, 1'b0, 30);
    check("ovf_flag", bus.evt_overflow, 1);
    check("ovf_hold", {bus.evt_valid, bus.evt_chan, bus.evt_press}, {1'b1, 3'd3, 1'b1});
    run(5'b00000, 1'b1, 4);
    check("ovf_n", hs_log.size(), 2);
    if (hs_log.size() > 1) check("ovf_second", hs_log[1], {3'd3, 1'b0});

    // Reset while an event and a pending change are outstanding
    hs_log.delete();
    run(5'b00011, 1'b0, 30);
    check("mid_valid", bus.evt_valid, 1);
    step(5'b00000, 1'b0, 1'b1);
    check("mid_rst_out", {level, bus.evt_valid, bus.evt_chan, bus.evt_press, bus.evt_overflow}, 0);
    run(5'b00000, 1'b1, 30);
    check("mid_stale", hs_log.size(), 0);

    // Randomized traffic against the model
    cur = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) cur = cur ^ 5'(1 << $urandom_range(0, N - 1));
      rdy = ((k / 200) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 999) == 0);
      step(cur, rdy, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
